// File: rtl/fb_swap_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : fb_swap_scheduler
// Purpose  : Double-buffer swap scheduler for the LED matrix framebuffer.
//            Watches the scan engine's row latch, row address and bit-plane
//            mask to find true frame boundaries, and flips the read/write bank
//            selects only at such a boundary so a partially written frame is
//            never displayed.
// Ports    : clk_in, reset (async, active-high)
//            row_latch, row_address[3:0], brightness_mask[5:0] - scan engine
//            swap_req           - one-cycle host request to swap banks
//            rd_bank / wr_bank  - bank selects (wr_bank is always ~rd_bank)
//            swap_pending       - request accepted, not yet serviced
//            swap_ack           - one-cycle pulse when the banks flip
//            frame_start        - one-cycle pulse per detected frame boundary
//            frame_count[7:0]   - free-running frame counter
//            req_dropped        - sticky: request arrived while busy
//            timeout_flag       - sticky: a watchdog-forced swap occurred
// Options  : FB_SWAP_TIMEOUT_EN - build the pending-swap watchdog. Without it
//            a pending swap waits indefinitely and timeout_flag is 0.
// Revision : 1.0 - initial release
//==============================================================================
module fb_swap_scheduler #(
    parameter logic [3:0]  MIN_FRAMES     = 4'd1,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       row_latch,
    input  logic [3:0] row_address,
    input  logic [5:0] brightness_mask,
    input  logic       swap_req,
    output logic       rd_bank,
    output logic       wr_bank,
    output logic       swap_pending,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       req_dropped,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_latch_q;
    logic       r_rise;
    logic       r_frame_start;
    logic       r_swap_ack;
    logic       r_rd_bank;
    logic       r_req_dropped;
    logic [7:0] r_frame_count;
    logic [3:0] r_shown;

    logic       w_rise;
    logic       w_boundary;
    logic       w_min_met;
    logic       w_timeout;

    // The address/mask presented with a latch describe the *next* row, and
    // are only guaranteed settled one cycle after the latch rises, so the
    // boundary test looks at them while r_rise is high.
    assign w_rise     = row_latch & ~r_latch_q;
    assign w_boundary = r_rise && (row_address == 4'd0) &&
                        (brightness_mask == 6'b100000);

    // Counts the frame currently being announced by r_frame_start.
    assign w_min_met  = ({1'b0, r_shown} + 5'd1) >= {1'b0, MIN_FRAMES};

`ifdef FB_SWAP_TIMEOUT_EN
    logic [19:0] r_pend_cnt;
    logic        r_timeout_flag;

    assign w_timeout = (r_state == ST_PENDING) &&
                       (r_pend_cnt == (TIMEOUT_CYCLES - 20'd1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_pend_cnt     <= 20'd0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == ST_PENDING) begin
                r_pend_cnt <= r_pend_cnt + 20'd1;
            end else begin
                r_pend_cnt <= 20'd0;
            end
            // Only a swap the boundary logic would not have taken is "forced".
            if (w_timeout && !(r_frame_start && w_min_met)) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    // Watchdog not built; the parameter stays so both builds share one
    // instantiation signature.
    assign w_timeout    = 1'b0;
    assign timeout_flag = 1'b0 & (TIMEOUT_CYCLES == 20'd0);
`endif

    // State register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (swap_req) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if ((r_frame_start && w_min_met) || w_timeout) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Boundary detection, counters, bank select and flags
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_latch_q     <= 1'b0;
            r_rise        <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
            r_shown       <= 4'd0;
            r_swap_ack    <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            r_latch_q     <= row_latch;
            r_rise        <= w_rise;
            r_frame_start <= w_boundary;
            r_swap_ack    <= (r_state == ST_SWAP);

            if (r_frame_start) begin
                r_frame_count <= r_frame_count + 8'd1;
            end

            // A swap restarts the display-time count, even if a boundary
            // lands on the same cycle (possible only with a forced swap).
            if (r_state == ST_SWAP) begin
                r_rd_bank <= ~r_rd_bank;
                r_shown   <= 4'd0;
            end else if (r_frame_start && (r_shown != 4'd15)) begin
                r_shown <= r_shown + 4'd1;
            end

            if (swap_req && (r_state != ST_IDLE)) begin
                r_req_dropped <= 1'b1;
            end
        end
    end

    assign rd_bank      = r_rd_bank;
    assign wr_bank      = ~r_rd_bank;
    assign swap_pending = (r_state == ST_PENDING);
    assign swap_ack     = r_swap_ack;
    assign frame_start  = r_frame_start;
    assign frame_count  = r_frame_count;
    assign req_dropped  = r_req_dropped;

endmodule
`default_nettype wire

// File: doc/fb_swap_scheduler.md
# fb_swap_scheduler

Double-buffer swap scheduler for the LED matrix framebuffer. It watches the scan engine's row latch, row address and brightness mask to find true frame boundaries. It accepts swap requests from the host/pattern writer and flips the read and write bank selects only at a frame boundary, so a partially written frame is never displayed. It sits between the scan engine and the framebuffer RAM bank muxes.

## Interface
- `MIN_FRAMES`, 4'd1: minimum completed frames a bank is displayed before it may be swapped out; range 1-15.
- `TIMEOUT_CYCLES`, 20'd1000000: pending-swap watchdog limit in `clk_in` cycles. Used only with `FB_SWAP_TIMEOUT_EN`.
- `reset` input 1: reset, asynchronous, active-high.
- `clk_in` input 1: clock.
- `row_latch` input 1: scan engine row latch pulse, synchronous to `clk_in`.
- `row_address` input 4: scan engine next row address.
- `brightness_mask` input 6: scan engine next bit-plane mask.
- `swap_req` input 1: one-cycle request to swap banks once the back bank is fully written.
- `rd_bank` output 1: bank read by the pixel fetch path.
- `wr_bank` output 1: bank writable by the host; always `~rd_bank`.
- `swap_pending` output 1: a request has been accepted and is not yet serviced.
- `swap_ack` output 1: one-cycle pulse on the cycle the banks flip.
- `frame_start` output 1: one-cycle pulse at each detected frame boundary.
- `frame_count` output 8: free-running frame counter.
- `req_dropped` output 1: sticky flag, set when `swap_req` arrives while a swap is already pending.
- `timeout_flag` output 1: sticky flag, set on a forced swap. Tied to 0 without the macro.

## Operation
- Boundary detection:
  - Register `row_latch` into `latch_q`.
  - A rise is `row_latch & ~latch_q`.
  - One cycle after a rise, sample `row_address == 4'd0` and `brightness_mask == 6'b100000`. If both hold, pulse `frame_start`.
  - Any other rise produces no pulse.
- `frame_count` increments on every `frame_start` and wraps 8'hFF -> 8'h00.
- `shown` is a 4-bit count of frames displayed since the last swap:
  - Cleared on a swap.
  - Incremented on `frame_start`, saturating at 15.
- State machine:
  - IDLE: on `swap_req`, go to PENDING.
  - PENDING: on `frame_start` with `shown + 1 >= MIN_FRAMES`, go to SWAP. A `frame_start` that does not meet the condition keeps the state at PENDING.
  - SWAP: lasts one cycle. Toggle `rd_bank`, pulse `swap_ack`, clear `shown`, return to IDLE.
  - `swap_pending` is high in PENDING only.
- `swap_req` in PENDING or SWAP is ignored and sets `req_dropped`. A request on the same cycle as a `frame_start` in IDLE goes to PENDING and waits for the next boundary.
- `req_dropped` and `timeout_flag` clear only on reset.

## Timing
- Reset values:
  - `rd_bank` = 0, `wr_bank` = 1.
  - State IDLE, `swap_pending` = 0, `swap_ack` = 0, `frame_start` = 0.
  - `frame_count` = 0, `shown` = 0.
  - Both sticky flags = 0.
- `frame_start` goes high 2 cycles after the `row_latch` rising-edge cycle.
- `swap_pending` goes high the cycle after `swap_req`.
- PENDING -> SWAP on the cycle after `frame_start`. `swap_ack` and the new `rd_bank`/`wr_bank` become visible 1 cycle later.
- Latency from the qualifying `row_latch` rise to the `rd_bank` flip is 4 cycles. This sits well inside the 64-column load window.
- An asynchronous reset mid-PENDING or mid-SWAP drops the request. Banks return to 0/1 immediately.

## Configuration
- `FB_SWAP_TIMEOUT_EN` defined:
  - A 20-bit counter runs while in PENDING and clears on leaving PENDING.
  - When it reaches `TIMEOUT_CYCLES - 1`, go to SWAP without waiting for a boundary and set `timeout_flag`. This covers a stalled scan.
- `FB_SWAP_TIMEOUT_EN` not defined:
  - No counter is built and `timeout_flag` is a constant 0.
  - PENDING waits indefinitely.

## Test plan
- Reset, then run 3 frames (16 rows x 6 planes each) with no request -> `frame_count` = 3, `rd_bank` = 0, `wr_bank` = 1, no `swap_ack`.
- `swap_req` mid-frame with `MIN_FRAMES` = 1 -> `swap_pending` = 1 until the next frame boundary. `swap_ack` pulses 1 cycle at boundary + 1, and `rd_bank` becomes 1.
- `MIN_FRAMES` = 3, request right after a swap -> swap occurs at the 3rd `frame_start` after that swap, not earlier.
- Second `swap_req` while PENDING -> `req_dropped` = 1, exactly one swap, `rd_bank` toggles once.
- `swap_req` coincident with `frame_start` -> swap deferred to the following boundary. Also: assert reset while PENDING -> `swap_pending` = 0, `rd_bank` = 0.
- With `FB_SWAP_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 100, `row_latch` held low after a request -> SWAP after 100 PENDING cycles, `timeout_flag` = 1, `rd_bank` toggled.
